square_drawer: RTL and testbench
================================

Name: square_drawer

Overview:
- Downstream consumer of the square picker. Takes one square request (squareX, colour) and rasterises a SQUARE_SIZE x SQUARE_SIZE block into the VGA adapter, one pixel per clock.
- Drives the adapter's x, y, colour and plot inputs directly.
- Exposes busy/done so the picker's slow state cadence (one square per 17 ticks) can be verified as never overrunning the drawer.

Parameters:
- SQUARE_SIZE, 4: edge length of the square in pixels. Legal range 1..8.
- ROW_Y, 7'd56: fixed y-coordinate of the square's top row (note lane).
- SCREEN_W, 8'd160: visible width. Pixels with x >= SCREEN_W are suppressed.
- SCREEN_H, 7'd120: visible height. Pixels with y >= SCREEN_H are suppressed.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- clear_b  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled on the rising edge of clock.
- squareX  in  8  x-coordinate of the square's top-left pixel.
- colour  in  3  colour of the square (RED = 3'b100, BLACK = 3'b000, any 3-bit value accepted).
- vga_x  out  8  pixel x to the adapter.
- vga_y  out  7  pixel y to the adapter.
- vga_colour  out  3  pixel colour to the adapter.
- plot  out  1  adapter write enable; high for exactly one cycle per written pixel.
- busy  out  1  high while a request is in progress (DRAW or DONE).
- done  out  1  one-cycle pulse after the last pixel.

Behaviour:
- Reset: clear_b low asynchronously forces state IDLE and clears col, row, base_x, base_col and all outputs (vga_x = 0, vga_y = 0, vga_colour = 0, plot = 0, busy = 0, done = 0). This applies immediately, including mid-square; the partially drawn square is left on screen and there is no resume.
- State machine, three states:
  - IDLE: start = 1 latches squareX into base_x and colour into base_col, clears col and row, and moves to DRAW. start = 0 stays in IDLE.
  - DRAW: each cycle emits the pixel (base_x + col, ROW_Y + row).
    - col increments every cycle.
    - At col = SQUARE_SIZE-1, col wraps to 0 and row increments.
    - At col = row = SQUARE_SIZE-1, the next state is DONE.
  - DONE: done = 1 for one cycle. start = 1 here latches a new request and goes straight to DRAW (back-to-back). Otherwise the next state is IDLE.
- Outputs are all registered. Assert start at edge N:
  - The first pixel appears with plot = 1 in the cycle after edge N.
  - Pixels occupy SQUARE_SIZE^2 consecutive cycles in raster order, with col varying fastest.
  - done is high in the following cycle.
  - Total occupancy is SQUARE_SIZE^2 + 1 cycles, which is 17 for the default, exactly matching the upstream cadence.
- busy = 1 in DRAW and DONE. start while in DRAW is ignored and not queued.
- base_x and base_col are frozen for the whole square; changes on squareX or colour during DRAW have no effect.
- Arithmetic:
  - Pixel x is computed 9 bits wide (base_x + col). If the result is >= SCREEN_W, including carry into bit 8, plot = 0 for that pixel. vga_x still shows the low 8 bits and timing is unchanged.
  - The same clipping rule applies to y against SCREEN_H.
  - There is no wrap-around drawing.
- When plot = 0 in IDLE and DONE, vga_x, vga_y and vga_colour hold their last values.

Decomposition:
- Shared package (vga_pkg) holds:
  - colour constants RED and BLACK;
  - SCREEN_W and SCREEN_H;
  - the state encoding IDLE / DRAW / DONE as 2-bit localparams.
- One sub-module, square_pixel_counter: a 2-D col/row counter with clear, enable and a last flag (asserted at col = row = SQUARE_SIZE-1). The FSM and output registers stay in square_drawer.

Test Plan:
- Reset mid-draw:
  - Stimulus: start with squareX = 8'd10, colour = 3'b100; pull clear_b low after 5 plot cycles.
  - Required: plot, busy and done drop to 0 immediately (asynchronously); the next start draws a full 16 pixels from (10, 56).
- Basic draw:
  - Stimulus: after reset, start = 1 for one cycle with squareX = 8'd5, colour = 3'b100.
  - Required: 16 consecutive plot cycles at x = 5..8, y = 56..59, raster order, vga_colour = 100; done pulses in cycle 17; busy = 1 for cycles 1..17.
- Input freeze and start-while-busy:
  - Stimulus: during a square, change colour to 3'b000 and pulse start at pixel 3.
  - Required: all 16 pixels stay 100; no second square is drawn; total plot count = 16.
- Back-to-back:
  - Stimulus: hold start = 1 with squareX = 0 then 5, stepping squareX every 17 cycles as the picker does.
  - Required: the second square's first plot occurs in the cycle immediately after done; no gap and no lost request.
- Right-edge clipping:
  - Stimulus: squareX = 8'd158.
  - Required: plot = 1 only for x = 158 and 159 (8 pixels); x = 160 and 161 have plot = 0; done still pulses at cycle 17.
- Overflow:
  - Stimulus: squareX = 8'd254.
  - Required: plot = 0 for all 16 pixels (x >= 254 or carry); no wrap to x = 0 or 1; done at cycle 17.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA drawing blocks: colours, screen extent and
// the square drawer's state encoding.
package vga_pkg;

    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] BLACK = 3'b000;

    localparam logic [7:0] SCREEN_W = 8'd160;
    localparam logic [6:0] SCREEN_H = 7'd120;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // x is 9 bits so a carry out of base_x + col counts as off-screen
    function automatic logic on_screen(input logic [8:0] x, input logic [7:0] y,
                                       input logic [7:0] w, input logic [6:0] h);
        return (x < {1'b0, w}) && (y < {1'b0, h});
    endfunction

endpackage

// File: rtl/square_pixel_counter.sv
// Two-dimensional col/row counter walking a SIZE x SIZE block in raster
// order; next-state values are exposed so the caller can register a pixel.
module square_pixel_counter #(
    parameter int SIZE = 4
) (
    input  logic       clock,
    input  logic       clear_b,
    input  logic       clear,
    input  logic       en,
    output logic [2:0] col,
    output logic [2:0] row,
    output logic [2:0] nxt_col,
    output logic [2:0] nxt_row,
    output logic       last
);

    localparam logic [2:0] MAX = 3'(SIZE - 1);

    assign last = (col == MAX) && (row == MAX);

    always_comb begin
        nxt_col = col;
        nxt_row = row;
        if (clear) begin
            nxt_col = 3'd0;
            nxt_row = 3'd0;
        end else if (en) begin
            if (col == MAX) begin
                nxt_col = 3'd0;
                nxt_row = row + 3'd1;
            end else begin
                nxt_col = col + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            col <= 3'd0;
            row <= 3'd0;
        end else begin
            col <= nxt_col;
            row <= nxt_row;
        end
    end

endmodule

// File: rtl/square_drawer.sv
// Rasterises one SQUARE_SIZE x SQUARE_SIZE block per request into the VGA
// adapter, one registered pixel per clock, with off-screen pixels suppressed.
//
//  state | meaning
//  IDLE  | waiting for start
//  DRAW  | output register holds pixel (col,row) of the current square
//  DONE  | done pulse; start here chains straight into the next square
module square_drawer #(
    parameter int         SQUARE_SIZE = 4,
    parameter logic [6:0] ROW_Y       = 7'd56,
    parameter logic [7:0] SCREEN_W    = vga_pkg::SCREEN_W,
    parameter logic [6:0] SCREEN_H    = vga_pkg::SCREEN_H
) (
    input  logic       clock,
    input  logic       clear_b,
    input  logic       start,
    input  logic [7:0] squareX,
    input  logic [2:0] colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    import vga_pkg::*;

    logic [1:0] state;
    logic [7:0] base_x;
    logic [2:0] base_col;
    logic [2:0] col, row, nxt_col, nxt_row;
    logic       last;
    logic       accept;
    logic [8:0] px;
    logic [7:0] py;

    assign accept = start && ((state == IDLE) || (state == DONE));

    square_pixel_counter #(.SIZE(SQUARE_SIZE)) u_cnt (
        .clock   (clock),
        .clear_b (clear_b),
        .clear   (accept),
        .en      ((state == DRAW) && !last),
        .col     (col),
        .row     (row),
        .nxt_col (nxt_col),
        .nxt_row (nxt_row),
        .last    (last)
    );

    assign px = {1'b0, base_x} + {6'd0, nxt_col};
    assign py = {1'b0, ROW_Y} + {5'd0, nxt_row};

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            state      <= IDLE;
            base_x     <= 8'd0;
            base_col   <= 3'd0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            if (accept) begin
                // pixel (0,0) goes out on the accepting edge itself
                state      <= DRAW;
                busy       <= 1'b1;
                base_x     <= squareX;
                base_col   <= colour;
                vga_x      <= squareX;
                vga_y      <= ROW_Y;
                vga_colour <= colour;
                plot       <= on_screen({1'b0, squareX}, {1'b0, ROW_Y}, SCREEN_W, SCREEN_H);
            end else begin
                case (state)
                    DRAW: begin
                        if (last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            vga_x      <= px[7:0];
                            vga_y      <= py[6:0];
                            vga_colour <= base_col;
                            plot       <= on_screen(px, py, SCREEN_W, SCREEN_H);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    IDLE:    busy  <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_square_drawer.sv
// Scoreboard bench for square_drawer: stimulus pushes the expected pixels,
// a negedge monitor pops and compares each plotted pixel.
module tb_square_drawer;

    localparam int SZ = 4;

    logic       clock = 1'b0;
    logic       clear_b = 1'b0;
    logic       start = 1'b0;
    logic [7:0] squareX = 8'd0;
    logic [2:0] colour = 3'd0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot, busy, done;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   plot_cnt = 0;

    square_drawer #(.SQUARE_SIZE(SZ)) dut (
        .clock      (clock),
        .clear_b    (clear_b),
        .start      (start),
        .squareX    (squareX),
        .colour     (colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic bit vis(input int sx, input int i);
        int x, y;
        x = sx + i % SZ;
        y = 56 + i / SZ;
        return (x < 160) && (y < 120);
    endfunction

    task automatic push_square(input int sx, input int c);
        pix_t p;
        for (int i = 0; i < SZ * SZ; i++) begin
            if (vis(sx, i)) begin
                p.x = 8'(sx + i % SZ);
                p.y = 7'(56 + i / SZ);
                p.c = 3'(c);
                sb.push_back(p);
            end
        end
    endtask

    function automatic int vis_count(input int sx);
        int n = 0;
        for (int i = 0; i < SZ * SZ; i++) if (vis(sx, i)) n++;
        return n;
    endfunction

    always @(negedge clock) begin
        if (plot) begin
            pix_t e;
            plot_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_plot", {16'd0, vga_x, 1'b0, vga_y}, -1);
            end else begin
                e = sb.pop_front();
                check("pix_x", vga_x, e.x);
                check("pix_y", vga_y, e.y);
                check("pix_colour", vga_colour, e.c);
            end
        end
    end

    // One square from the start strobe; cycle k is the k-th negedge after edge N.
    task automatic do_square(input int sx, input int c, input bit freeze);
        int p0;
        p0 = plot_cnt;
        @(negedge clock);
        start = 1'b1; squareX = 8'(sx); colour = 3'(c);
        push_square(sx, c);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
            if (freeze && k == 3) begin colour = 3'b000; start = 1'b1; squareX = 8'd99; end
            if (freeze && k == 4) start = 1'b0;
            check($sformatf("busy_x%0d_k%0d", sx, k), busy, (k <= 17) ? 1 : 0);
            check($sformatf("done_x%0d_k%0d", sx, k), done, (k == 17) ? 1 : 0);
            check($sformatf("plot_x%0d_k%0d", sx, k), plot, (k <= 16 && vis(sx, k - 1)) ? 1 : 0);
        end
        check($sformatf("plot_count_x%0d", sx), plot_cnt - p0, vis_count(sx));
        check($sformatf("sb_empty_x%0d", sx), sb.size(), 0);
    endtask

    initial begin
        int p0;
        #12;
        check("rst_vga_x", vga_x, 0);
        check("rst_vga_y", vga_y, 0);
        check("rst_colour", vga_colour, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clock);
        clear_b = 1'b1;
        repeat (2) @(negedge clock);

        do_square(5, 3'b100, 1'b0);     // basic draw
        do_square(20, 3'b100, 1'b1);    // freeze and start-while-busy

        // back-to-back with start held high
        p0 = plot_cnt;
        @(negedge clock);
        start = 1'b1; squareX = 8'd0; colour = 3'b100;
        push_square(0, 3'b100);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clock);
            if (k == 1) begin squareX = 8'd5; push_square(5, 3'b100); end
            if (k == 34) start = 1'b0;
            check($sformatf("b2b_done_k%0d", k), done, (k == 17 || k == 34) ? 1 : 0);
            check($sformatf("b2b_busy_k%0d", k), busy, (k <= 34) ? 1 : 0);
            check($sformatf("b2b_plot_k%0d", k), plot, (k != 17 && k < 34) ? 1 : 0);
            if (k == 18) check("b2b_first_x", vga_x, 5);
        end
        check("b2b_plot_count", plot_cnt - p0, 32);
        check("b2b_sb_empty", sb.size(), 0);

        do_square(158, 3'b010, 1'b0);   // right-edge clip
        do_square(254, 3'b111, 1'b0);   // 8-bit overflow

        // reset mid-draw
        @(negedge clock);
        start = 1'b1; squareX = 8'd10; colour = 3'b100;
        push_square(10, 3'b100);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
        end
        #2 clear_b = 1'b0;
        #1;
        check("midrst_plot", plot, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_vga_x", vga_x, 0);
        check("midrst_sb_left", sb.size(), 11);
        sb.delete();
        @(negedge clock);
        clear_b = 1'b1;
        @(negedge clock);
        do_square(10, 3'b100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
